// File: rtl/axis_multichannel_dsm_dac.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
// Module   : axis_multichannel_dsm_dac
// Purpose  : Multi-channel 1st/2nd-order saturating delta-sigma modulator fed
//            by AXI-Stream PCM frames, each frame held for OSR steps.
// Revision : 1.0
// ============================================================================
module axis_multichannel_dsm_dac #(
  parameter int WIDTH     = 16,
  parameter int CHANNELS  = 2,
  parameter int OSR       = 64,
  parameter int EXT_ACC_1 = 2,
  parameter int EXT_ACC_2 = 8
) (
  input  logic                      aclk,
  input  logic                      arst_n,
  input  logic                      order_sel,
  input  logic [CHANNELS*WIDTH-1:0] s_axis_data_tdata,
  input  logic                      s_axis_data_tvalid,
  output logic                      s_axis_data_tready,
  output logic [CHANNELS-1:0]       m_axis_data_tdata,
  output logic                      m_axis_data_tvalid,
  output logic                      underrun
);

  localparam int A1    = WIDTH + EXT_ACC_1;
  localparam int A2    = WIDTH + EXT_ACC_2;
  localparam int S1    = A1 + 2;
  localparam int S2    = ((A1 > A2) ? A1 : A2) + 2;
  localparam int CNT_W = $clog2(OSR);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OSR - 1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t                    state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [CHANNELS*WIDTH-1:0] hold_q, hold_d;
  logic [CHANNELS*WIDTH-1:0] active_q, active_d;
  logic                      hold_full_q, hold_full_d;
  logic                      order_q, order_d;
  logic                      tready_q, tready_d;
  logic                      tvalid_q, tvalid_d;
  logic                      underrun_q, underrun_d;
  logic                      accept;
  logic                      load;
  logic                      step;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    active_d    = active_q;
    order_d     = order_q;
    underrun_d  = 1'b0;
    load        = 1'b0;
    step        = 1'b0;
    accept      = s_axis_data_tvalid & tready_q;

    case (state_q)
      ST_IDLE: begin
        if (hold_full_q) begin
          load    = 1'b1;
          state_d = ST_RUN;
          cnt_d   = '0;
        end
      end
      ST_RUN: begin
        step = 1'b1;
        // The boundary step still runs on the old frame; the swap lands after it.
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (hold_full_q) begin
            load = 1'b1;
          end else begin
            underrun_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (load) begin
      active_d    = hold_q;
      order_d     = order_sel;
      hold_full_d = 1'b0;
    end
    if (accept) begin
      hold_d      = s_axis_data_tdata;
      hold_full_d = 1'b1;
    end

    tready_d = ~hold_full_d;
    tvalid_d = tvalid_q | step;
  end

  always_ff @(posedge aclk) begin
    if (!arst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      active_q    <= '0;
      order_q     <= 1'b0;
      tready_q    <= 1'b0;
      tvalid_q    <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      active_q    <= active_d;
      order_q     <= order_d;
      tready_q    <= tready_d;
      tvalid_q    <= tvalid_d;
      underrun_q  <= underrun_d;
    end
  end

  assign s_axis_data_tready = tready_q;
  assign m_axis_data_tvalid = tvalid_q;
  assign underrun           = underrun_q;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic signed [A1-1:0] acc1_q, acc1_d, acc1_sat;
    logic signed [A2-1:0] acc2_q, acc2_d, acc2_sat;
    logic                 y_q, y_d;
    logic signed [S1-1:0] x_ext, acc1_ext, fb1, sum1;
    logic signed [S2-1:0] acc2_ext, acc1n_ext, fb2, sum2;

    always_comb begin
      x_ext    = {{(S1-WIDTH){active_q[c*WIDTH+WIDTH-1]}}, active_q[c*WIDTH +: WIDTH]};
      acc1_ext = {{(S1-A1){acc1_q[A1-1]}}, acc1_q};
      fb1      = y_q ? {{(S1-WIDTH){1'b0}}, 1'b1, {(WIDTH-1){1'b0}}}
                     : {{(S1-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};
      sum1     = acc1_ext + x_ext - fb1;

      // In range when the guard bits all agree with the target sign bit.
      if ((&sum1[S1-1:A1-1]) || (~|sum1[S1-1:A1-1])) begin
        acc1_sat = sum1[A1-1:0];
      end else if (sum1[S1-1]) begin
        acc1_sat = {1'b1, {(A1-1){1'b0}}};
      end else begin
        acc1_sat = {1'b0, {(A1-1){1'b1}}};
      end

      acc2_ext  = {{(S2-A2){acc2_q[A2-1]}}, acc2_q};
      acc1n_ext = {{(S2-A1){acc1_sat[A1-1]}}, acc1_sat};
      fb2       = y_q ? {{(S2-WIDTH){1'b0}}, 1'b1, {(WIDTH-1){1'b0}}}
                      : {{(S2-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};
      sum2      = acc2_ext + acc1n_ext - fb2;

      if ((&sum2[S2-1:A2-1]) || (~|sum2[S2-1:A2-1])) begin
        acc2_sat = sum2[A2-1:0];
      end else if (sum2[S2-1]) begin
        acc2_sat = {1'b1, {(A2-1){1'b0}}};
      end else begin
        acc2_sat = {1'b0, {(A2-1){1'b1}}};
      end

      acc1_d = acc1_q;
      acc2_d = acc2_q;
      y_d    = y_q;
      if (step) begin
        acc1_d = acc1_sat;
        if (order_q) begin
          acc2_d = acc2_sat;
          y_d    = ~acc2_sat[A2-1];
        end else begin
          acc2_d = '0;
          y_d    = ~acc1_sat[A1-1];
        end
      end
    end

    always_ff @(posedge aclk) begin
      if (!arst_n) begin
        acc1_q <= '0;
        acc2_q <= '0;
        y_q    <= 1'b0;
      end else begin
        acc1_q <= acc1_d;
        acc2_q <= acc2_d;
        y_q    <= y_d;
      end
    end

    assign m_axis_data_tdata[c] = y_q;
  end

endmodule
`default_nettype wire
